// File: rtl/frame_window_retimer.sv
// Extracts a fixed WIN_W x WIN_H window from a cropped RGB stream, regenerates DE,
// adds window coordinates and SOF/EOL markers, and measures incoming frame geometry.
module frame_window_retimer #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_BITS   = 12,
  parameter int WIN_W      = 640,
  parameter int WIN_H      = 480
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CNT_BITS-1:0]   win_x_i,
  input  logic [CNT_BITS-1:0]   win_y_i,
  input  logic                  vs_i,
  input  logic                  hs_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vs_o,
  output logic                  hs_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_BITS-1:0]   x_o,
  output logic [CNT_BITS-1:0]   y_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic [CNT_BITS-1:0]   meas_w_o,
  output logic [CNT_BITS-1:0]   meas_h_o,
  output logic                  fmt_err_o
);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS:0]   WIN_W_E  = (CNT_BITS+1)'(WIN_W);
  localparam logic [CNT_BITS:0]   WIN_H_E  = (CNT_BITS+1)'(WIN_H);
  localparam logic [CNT_BITS-1:0] EOL_X    = CNT_BITS'(WIN_W - 1);

  // Stage 1: registered inputs and edge flags
  logic                  vs_q, hs_q, de_q;
  logic                  vs_rise_q, de_fall_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_BITS-1:0]   win_x_q, win_y_q;

  // Counters, window shadows and measurement accumulators
  logic [0:0]            state_q;
  logic [CNT_BITS-1:0]   cx_q, cy_q;
  logic [CNT_BITS-1:0]   wx_q, wy_q;
  logic [CNT_BITS-1:0]   ref_w_q;
  logic                  err_acc_q;
  logic                  line_seen_q;

  // NOTE: every register here is written with non-blocking assignments so that all
  // stages read the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
      vs_rise_q <= 1'b0;
      de_fall_q <= 1'b0;
      data_q    <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
    end else begin
      vs_q      <= vs_i;
      hs_q      <= hs_i;
      de_q      <= de_i;
      vs_rise_q <= vs_i & ~vs_q;
      de_fall_q <= ~de_i & de_q;
      data_q    <= data_i;
      win_x_q   <= win_x_i;
      win_y_q   <= win_y_i;
    end
  end

  // cx_q is the column of the pixel currently in stage 1; on the de-fall cycle it
  // still holds the finished line's pixel count, which is the measured length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cx_q <= '0;
    end else if (de_q) begin
      cx_q <= (cx_q == CNT_MAX) ? cx_q : cx_q + CNT_ONE;
    end else begin
      cx_q <= '0;
    end
  end

  // A vs rise outranks a coincident de fall, so the new frame always starts at row 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cy_q <= '0;
    end else if (vs_rise_q) begin
      cy_q <= '0;
    end else if (de_fall_q) begin
      cy_q <= (cy_q == CNT_MAX) ? cy_q : cy_q + CNT_ONE;
    end
  end

  // Wide sums keep window ends near the top of the counter range from aliasing.
  logic [CNT_BITS:0] wx_end, wy_end;
  logic              frame_bad;

  always_comb begin
    wx_end    = {1'b0, wx_q} + WIN_W_E;
    wy_end    = {1'b0, wy_q} + WIN_H_E;
    frame_bad = err_acc_q | ({1'b0, ref_w_q} < wx_end) | ({1'b0, cy_q} < wy_end);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      wx_q        <= '0;
      wy_q        <= '0;
      ref_w_q     <= '0;
      err_acc_q   <= 1'b0;
      line_seen_q <= 1'b0;
      meas_w_o    <= '0;
      meas_h_o    <= '0;
      fmt_err_o   <= 1'b0;
    end else if (vs_rise_q) begin
      // Publish the finished frame only if it was tracked from its own start.
      if (state_q == ST_LOCK && line_seen_q) begin
        meas_w_o  <= ref_w_q;
        meas_h_o  <= cy_q;
        fmt_err_o <= frame_bad;
      end
      state_q     <= ST_LOCK;
      wx_q        <= win_x_q;
      wy_q        <= win_y_q;
      ref_w_q     <= '0;
      err_acc_q   <= 1'b0;
      line_seen_q <= 1'b0;
    end else if (de_fall_q) begin
      if (!line_seen_q) begin
        ref_w_q     <= cx_q;
        line_seen_q <= 1'b1;
      end else if (cx_q != ref_w_q) begin
        err_acc_q <= 1'b1;
      end
    end
  end

  // Stage 2: window compare and registered outputs
  logic                in_win;
  logic [CNT_BITS-1:0] x_rel, y_rel;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    in_win = 1'b0;
    x_rel  = cx_q - wx_q;
    y_rel  = cy_q - wy_q;
    if (state_q == ST_LOCK && de_q &&
        {1'b0, cx_q} >= {1'b0, wx_q} && {1'b0, cx_q} < wx_end &&
        {1'b0, cy_q} >= {1'b0, wy_q} && {1'b0, cy_q} < wy_end) begin
      in_win = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_o   <= 1'b0;
      hs_o   <= 1'b0;
      de_o   <= 1'b0;
      data_o <= '0;
      x_o    <= '0;
      y_o    <= '0;
      sof_o  <= 1'b0;
      eol_o  <= 1'b0;
    end else begin
      vs_o   <= vs_q;
      hs_o   <= hs_q;
      de_o   <= in_win;
      data_o <= in_win ? data_q : '0;
      x_o    <= in_win ? x_rel : '0;
      y_o    <= in_win ? y_rel : '0;
      sof_o  <= in_win && x_rel == '0 && y_rel == '0;
      eol_o  <= in_win && x_rel == EOL_X;
    end
  end

endmodule
